// File: rtl/dmem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_port_arbiter
// Purpose  : Shares one fixed-latency data-memory port between the pipeline
//            MEM stage (P) and a debug/loader port (D). An FSM runs each
//            access, and the MEM-stage stall is held while a P access waits.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_port_arbiter #(
   parameter int AW       = 32,
   parameter int DW       = 32,
   parameter int MEM_LAT  = 1,
   parameter int MAX_WAIT = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          p_rd,
   input  logic          p_wr,
   input  logic [AW-1:0] p_addr,
   input  logic [DW-1:0] p_wdata,
   output logic          stall_mem,
   output logic          p_ack,
   output logic [DW-1:0] p_rdata,
   input  logic          d_req,
   input  logic          d_we,
   input  logic [AW-1:0] d_addr,
   input  logic [DW-1:0] d_wdata,
   output logic          d_ack,
   output logic [DW-1:0] d_rdata,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_DONE  = 2'd3
   } arbState_t;

   localparam logic       c_OWNER_P  = 1'b0;
   localparam logic       c_OWNER_D  = 1'b1;
   localparam logic [3:0] c_LAT_INIT = 4'(MEM_LAT - 1);
   localparam logic [7:0] c_MAX_WAIT = 8'(MAX_WAIT);

   arbState_t     r_state;
   logic          r_owner;
   logic [3:0]    r_latCnt;
   logic [7:0]    r_dWait;
   logic          r_memEn;
   logic          r_memWe;
   logic [AW-1:0] r_memAddr;
   logic [DW-1:0] r_memWdata;
   logic [DW-1:0] r_pRdata;
   logic [DW-1:0] r_dRdata;
   logic          r_pAck;
   logic          r_dAck;

   logic          w_pReq;
   logic          w_grantD;

   // A simultaneous read+write from the pipeline is treated as a write.
   assign w_pReq   = p_rd | p_wr;
   // D wins when alone, or when it has lost MAX_WAIT arbitrations in a row.
   assign w_grantD = d_req & (~w_pReq | (r_dWait == c_MAX_WAIT));

   // Access sequencer: arbitration, memory strobe, latency count, acks.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= S_IDLE;
         r_owner    <= c_OWNER_P;
         r_latCnt   <= 4'd0;
         r_dWait    <= 8'd0;
         r_memEn    <= 1'b0;
         r_memWe    <= 1'b0;
         r_memAddr  <= '0;
         r_memWdata <= '0;
         r_pRdata   <= '0;
         r_dRdata   <= '0;
         r_pAck     <= 1'b0;
         r_dAck     <= 1'b0;
      end else begin
         r_memEn <= 1'b0;
         r_memWe <= 1'b0;
         r_pAck  <= 1'b0;
         r_dAck  <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_pReq | d_req) begin
                  r_state <= S_ISSUE;
                  r_memEn <= 1'b1;
                  if (w_grantD) begin
                     r_owner    <= c_OWNER_D;
                     r_memWe    <= d_we;
                     r_memAddr  <= d_addr;
                     r_memWdata <= d_wdata;
                     r_dWait    <= 8'd0;
                  end else begin
                     r_owner    <= c_OWNER_P;
                     r_memWe    <= p_wr;
                     r_memAddr  <= p_addr;
                     r_memWdata <= p_wdata;
                     if (d_req && (r_dWait != c_MAX_WAIT)) begin
                        r_dWait <= r_dWait + 8'd1;
                     end
                  end
               end
            end
            S_ISSUE: begin
               // r_memWe still holds the latched direction during ISSUE.
               if (r_memWe) begin
                  r_state <= S_DONE;
                  r_pAck  <= (r_owner == c_OWNER_P);
                  r_dAck  <= (r_owner == c_OWNER_D);
               end else begin
                  r_state  <= S_WAIT;
                  r_latCnt <= c_LAT_INIT;
               end
            end
            S_WAIT: begin
               if (r_latCnt == 4'd0) begin
                  r_state <= S_DONE;
                  if (r_owner == c_OWNER_P) begin
                     r_pRdata <= mem_rdata;
                     r_pAck   <= 1'b1;
                  end else begin
                     r_dRdata <= mem_rdata;
                     r_dAck   <= 1'b1;
                  end
               end else begin
                  r_latCnt <= r_latCnt - 4'd1;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   // Pipeline stalls on any P request until the P access reaches DONE.
   assign stall_mem = rst & w_pReq & ~((r_state == S_DONE) & (r_owner == c_OWNER_P));

   assign p_ack     = r_pAck;
   assign p_rdata   = r_pRdata;
   assign d_ack     = r_dAck;
   assign d_rdata   = r_dRdata;
   assign mem_en    = r_memEn;
   assign mem_we    = r_memWe;
   assign mem_addr  = r_memAddr;
   assign mem_wdata = r_memWdata;

endmodule
`default_nettype wire

// File: tb/tb_dmem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_port_arbiter
// Purpose  : Self-checking bench for dmem_port_arbiter. Instance A uses
//            MEM_LAT=1/MAX_WAIT=2, instance B uses MEM_LAT=3.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_port_arbiter;

   logic clk = 1'b0;
   logic rst = 1'b0;

   // Free-running clock, period 10.
   always #5 clk = ~clk;

   logic        aPRd = 1'b0, aPWr = 1'b0, aDReq = 1'b0, aDWe = 1'b0;
   logic [31:0] aPAddr = '0, aPWdata = '0, aDAddr = '0, aDWdata = '0;
   logic        aStall, aPAck, aDAck, aMemEn, aMemWe;
   logic [31:0] aPRdata, aDRdata, aMemAddr, aMemWdata, aMemRdata;

   logic        bPRd = 1'b0, bPWr = 1'b0, bDReq = 1'b0, bDWe = 1'b0;
   logic [31:0] bPAddr = '0, bPWdata = '0, bDAddr = '0, bDWdata = '0;
   logic        bStall, bPAck, bDAck, bMemEn, bMemWe;
   logic [31:0] bPRdata, bDRdata, bMemAddr, bMemWdata, bMemRdata;

   dmem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(1), .MAX_WAIT(2)) dutA (
      .clk(clk), .rst(rst),
      .p_rd(aPRd), .p_wr(aPWr), .p_addr(aPAddr), .p_wdata(aPWdata),
      .stall_mem(aStall), .p_ack(aPAck), .p_rdata(aPRdata),
      .d_req(aDReq), .d_we(aDWe), .d_addr(aDAddr), .d_wdata(aDWdata),
      .d_ack(aDAck), .d_rdata(aDRdata),
      .mem_en(aMemEn), .mem_we(aMemWe), .mem_addr(aMemAddr),
      .mem_wdata(aMemWdata), .mem_rdata(aMemRdata)
   );

   dmem_port_arbiter #(.AW(32), .DW(32), .MEM_LAT(3), .MAX_WAIT(8)) dutB (
      .clk(clk), .rst(rst),
      .p_rd(bPRd), .p_wr(bPWr), .p_addr(bPAddr), .p_wdata(bPWdata),
      .stall_mem(bStall), .p_ack(bPAck), .p_rdata(bPRdata),
      .d_req(bDReq), .d_we(bDWe), .d_addr(bDAddr), .d_wdata(bDWdata),
      .d_ack(bDAck), .d_rdata(bDRdata),
      .mem_en(bMemEn), .mem_we(bMemWe), .mem_addr(bMemAddr),
      .mem_wdata(bMemWdata), .mem_rdata(bMemRdata)
   );

   function automatic logic [31:0] initVal(input logic [7:0] a);
      return (a == 8'h10) ? 32'hDEADBEEF : {24'hC0DE00, a};
   endfunction

   // Memory A: one-cycle read latency; data is junk outside the valid cycle.
   logic [31:0] memA [256];
   bit          wrA  [256];
   logic        aVld = 1'b0;
   logic [31:0] aDat = '0;
   always @(posedge clk) begin
      if (aMemEn && aMemWe) begin
         memA[aMemAddr[7:0]] <= aMemWdata;
         wrA[aMemAddr[7:0]]  <= 1'b1;
      end
      aVld <= aMemEn && !aMemWe;
      aDat <= wrA[aMemAddr[7:0]] ? memA[aMemAddr[7:0]] : initVal(aMemAddr[7:0]);
   end
   assign aMemRdata = aVld ? aDat : 32'hBAADF00D;

   // Memory B: read-only, three-cycle read latency.
   logic [2:0]  bVld = 3'b000;
   logic [31:0] bDat [3];
   always @(posedge clk) begin
      bVld    <= {bVld[1:0], bMemEn && !bMemWe};
      bDat[0] <= initVal(bMemAddr[7:0]);
      bDat[1] <= bDat[0];
      bDat[2] <= bDat[1];
   end
   assign bMemRdata = bVld[2] ? bDat[2] : 32'hBAADF00D;

   int nCmp = 0;
   int nBad = 0;

   task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
      nCmp++;
      if (act !== exp) begin
         nBad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chkBit(input string name, input logic act, input logic exp);
      nCmp++;
      if (act !== exp) begin
         nBad++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic chkInt(input string name, input int act, input int exp);
      nCmp++;
      if (act != exp) begin
         nBad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Scoreboard of expected completions on instance A.
   typedef struct { bit isP; logic [31:0] data; } exp_t;
   exp_t        sbA[$];
   logic [31:0] shadow [256];
   logic [31:0] lastPRd = '0;
   logic [31:0] lastDRd = '0;

   task automatic popA(input string name);
      exp_t e;
      if (sbA.size() == 0) begin
         nCmp++;
         nBad++;
         $display("FAIL %s: ack with empty scoreboard", name);
      end else begin
         e = sbA.pop_front();
         chkBit({name, " owner"}, aPAck, e.isP);
         chk32({name, " rdata"}, e.isP ? aPRdata : aDRdata, e.data);
      end
   endtask

   // Called at a negedge; walks cycles until an ack on A (1 = current cycle).
   task automatic waitAckA(output int n, output bit isP, output int stalls);
      stalls = 0;
      isP    = 1'b0;
      for (n = 1; n <= 30; n++) begin
         #1;
         if (aPAck || aDAck) begin
            isP = aPAck;
            break;
         end
         if (aStall) stalls++;
         @(negedge clk);
      end
   endtask

   typedef struct { logic rd; logic wr; logic [31:0] addr; logic [31:0] wdata; int lat; string name; } vec_t;

   // One P access on A with no D traffic; checks latency, stall and strobe.
   task automatic runA(input vec_t v);
      int n;
      int stalls;
      int ens;
      bit got;
      aPRd = v.rd; aPWr = v.wr; aPAddr = v.addr; aPWdata = v.wdata;
      if (v.wr) shadow[v.addr[7:0]] = v.wdata;
      else      lastPRd = shadow[v.addr[7:0]];
      sbA.push_back('{1'b1, lastPRd});
      stalls = 0; ens = 0; got = 1'b0;
      for (n = 1; n <= 20; n++) begin
         #1;
         if (aMemEn) begin
            ens++;
            chkBit({v.name, " mem_we"}, aMemWe, v.wr);
            chk32({v.name, " mem_addr"}, aMemAddr, v.addr);
            if (v.wr) chk32({v.name, " mem_wdata"}, aMemWdata, v.wdata);
         end
         if (aPAck) begin
            got = 1'b1;
            break;
         end
         if (aStall) stalls++;
         @(negedge clk);
      end
      chkBit({v.name, " ack seen"}, got, 1'b1);
      chkInt({v.name, " latency"}, n, v.lat);
      chkInt({v.name, " stall cycles"}, stalls, v.lat - 1);
      chkInt({v.name, " mem_en pulses"}, ens, 1);
      chkBit({v.name, " stall at ack"}, aStall, 1'b0);
      if (got) popA(v.name);
      aPRd = 1'b0; aPWr = 1'b0;
      @(negedge clk);
   endtask

   vec_t vecs [6];

   initial begin
      int  n;
      int  st;
      int  enCyc;
      int  addrBad;
      bit  isP;

      for (int i = 0; i < 256; i++) shadow[i] = initVal(8'(i));
      vecs[0] = '{1'b1, 1'b0, 32'h10, 32'h0,        4, "rd 0x10"};
      vecs[1] = '{1'b0, 1'b1, 32'h20, 32'h12345678, 3, "wr 0x20"};
      vecs[2] = '{1'b1, 1'b0, 32'h20, 32'h0,        4, "rd 0x20"};
      vecs[3] = '{1'b1, 1'b1, 32'h30, 32'hCAFEF00D, 3, "rd+wr 0x30"};
      vecs[4] = '{1'b1, 1'b0, 32'h30, 32'h0,        4, "rd 0x30"};
      vecs[5] = '{1'b1, 1'b0, 32'h44, 32'h0,        4, "rd 0x44"};

      // Reset: outputs zero even with a P request present.
      aPRd = 1'b1; aPAddr = 32'h10;
      @(negedge clk); #1;
      chkBit("reset stall", aStall, 1'b0);
      chkBit("reset p_ack", aPAck, 1'b0);
      chkBit("reset d_ack", aDAck, 1'b0);
      chkBit("reset mem_en", aMemEn, 1'b0);
      chk32("reset p_rdata", aPRdata, 32'h0);
      chk32("reset mem_addr", aMemAddr, 32'h0);
      aPRd = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 6; i++) runA(vecs[i]);

      // P and D contend: P first, then D in the following IDLE.
      aPRd = 1'b1; aPAddr = 32'h50;
      aDReq = 1'b1; aDWe = 1'b0; aDAddr = 32'h40;
      lastPRd = shadow[8'h50]; lastDRd = shadow[8'h40];
      sbA.push_back('{1'b1, lastPRd});
      sbA.push_back('{1'b0, lastDRd});
      waitAckA(n, isP, st);
      chkBit("contend first is P", isP, 1'b1);
      chkInt("contend P latency", n, 4);
      chkInt("contend P stalls", st, 3);
      chkBit("contend stall at p_ack", aStall, 1'b0);
      popA("contend P");
      aPRd = 1'b0;
      @(negedge clk);
      waitAckA(n, isP, st);
      chkBit("contend second is D", isP, 1'b0);
      chkInt("contend D latency", n, 4);
      popA("contend D");
      aDReq = 1'b0;
      @(negedge clk);

      // Starvation limit: D write wins the third contended arbitration.
      aDReq = 1'b1; aDWe = 1'b1; aDAddr = 32'h60; aDWdata = 32'h0BADCAFE;
      aPRd = 1'b1; aPAddr = 32'h10;
      lastPRd = shadow[8'h10];
      sbA.push_back('{1'b1, lastPRd});
      waitAckA(n, isP, st);
      chkBit("starve arb1 P", isP, 1'b1);
      chkInt("starve arb1 latency", n, 4);
      popA("starve arb1");
      aPAddr = 32'h20;
      lastPRd = shadow[8'h20];
      sbA.push_back('{1'b1, lastPRd});
      @(negedge clk);
      waitAckA(n, isP, st);
      chkBit("starve arb2 P", isP, 1'b1);
      chkInt("starve arb2 latency", n, 4);
      popA("starve arb2");
      aPAddr = 32'h60;
      shadow[8'h60] = 32'h0BADCAFE;
      sbA.push_back('{1'b0, lastDRd});
      lastPRd = 32'h0BADCAFE;
      sbA.push_back('{1'b1, lastPRd});
      @(negedge clk);
      waitAckA(n, isP, st);
      chkBit("starve arb3 D", isP, 1'b0);
      chkInt("starve D write latency", n, 3);
      chkInt("starve stall during D", st, 2);
      chkBit("starve stall at d_ack", aStall, 1'b1);
      popA("starve D");
      aDReq = 1'b0;
      @(negedge clk);
      waitAckA(n, isP, st);
      chkBit("starve P after D", isP, 1'b1);
      chkInt("starve P latency", n, 4);
      chkInt("starve P stalls", st, 3);
      popA("starve P reads D write");
      aPRd = 1'b0;
      @(negedge clk);

      // After the D grant its wait count is clear, so P wins again.
      aDReq = 1'b1; aDWe = 1'b0; aDAddr = 32'h20;
      aPRd = 1'b1; aPAddr = 32'h44;
      lastPRd = shadow[8'h44]; lastDRd = shadow[8'h20];
      sbA.push_back('{1'b1, lastPRd});
      sbA.push_back('{1'b0, lastDRd});
      waitAckA(n, isP, st);
      chkBit("wait cleared P wins", isP, 1'b1);
      popA("wait cleared P");
      aPRd = 1'b0;
      @(negedge clk);
      waitAckA(n, isP, st);
      chkBit("wait cleared then D", isP, 1'b0);
      popA("wait cleared D");
      aDReq = 1'b0;
      @(negedge clk);

      // MEM_LAT=3 read on B: strobe timing, stall length, address hold.
      bPRd = 1'b1; bPAddr = 32'h24;
      st = 0; enCyc = 0; addrBad = 0;
      for (n = 1; n <= 30; n++) begin
         #1;
         if (bMemEn) enCyc = n;
         if (enCyc != 0 && bMemAddr !== 32'h24) addrBad++;
         if (bPAck) break;
         if (bStall) st++;
         @(negedge clk);
      end
      chkInt("lat3 latency", n, 6);
      chkInt("lat3 stalls", st, 5);
      chkInt("lat3 mem_en cycle", enCyc, 2);
      chkInt("lat3 addr unstable cycles", addrBad, 0);
      chk32("lat3 p_rdata", bPRdata, initVal(8'h24));
      bPRd = 1'b0;
      @(negedge clk);

      // Reset asserted while B is in WAIT.
      bPRd = 1'b1; bPAddr = 32'h28;
      @(negedge clk);
      @(negedge clk);
      #2;
      rst = 1'b0;
      #1;
      chkBit("midrst stall", bStall, 1'b0);
      chkBit("midrst p_ack", bPAck, 1'b0);
      chkBit("midrst mem_en", bMemEn, 1'b0);
      chk32("midrst p_rdata", bPRdata, 32'h0);
      chk32("midrst mem_addr", bMemAddr, 32'h0);
      chk32("midrst A d_rdata", aDRdata, 32'h0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      st = 0; enCyc = 0;
      for (n = 1; n <= 30; n++) begin
         #1;
         if (bMemEn) enCyc = n;
         if (bPAck) break;
         if (bStall) st++;
         @(negedge clk);
      end
      chkInt("postrst latency", n, 6);
      chkInt("postrst stalls", st, 5);
      chkInt("postrst mem_en cycle", enCyc, 2);
      chk32("postrst p_rdata", bPRdata, initVal(8'h28));
      bPRd = 1'b0;
      @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
      $finish;
   end

endmodule
`default_nettype wire
